// File: rtl/edge_event_sync.sv
// edge_event_sync: multi-channel async input conditioner.
// Sync, glitch filter, edge detect, event pulse, sticky flags.
module edge_event_sync #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int CW          = $clog2(FILT_LEN+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH-1:0]   din,
   input  logic [2*CH-1:0] mode,
   input  logic [CH-1:0]   force_ev,
   input  logic [CH-1:0]   ack,
   output logic [CH-1:0]   level,
   output logic [CH-1:0]   ev,
   output logic [CH-1:0]   flag,
   output logic [CH-1:0]   ovf,
   output logic            irq
);

   logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
   logic [CH-1:0]                  s;
   logic [CH-1:0]                  lvl;
   logic [CH-1:0]                  lvl_d;
   logic [CH-1:0][CW-1:0]          cnt;
   logic [CH-1:0]                  rise;
   logic [CH-1:0]                  fall;
   logic [CH-1:0]                  edge_ev;
   logic [CH-1:0]                  ovf_set;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift chain, one column per channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // Accept a new level only after it persists FILT_LEN cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (s[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(FILT_LEN-1)) begin
               lvl[i] <= s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Delayed level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_d <= '0;
      end else begin
         lvl_d <= lvl;
      end
   end

   assign rise = lvl & ~lvl_d;
   assign fall = ~lvl & lvl_d;

   // Qualify edges by the live mode bits; force bypasses mode
   always_comb begin
      edge_ev = '0;
      for (int i = 0; i < CH; i++) begin
         edge_ev[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
      end
   end

   assign ev      = edge_ev | force_ev;
   assign ovf_set = ev & flag & ~ack;

   // Sticky flag and overflow; a new event wins over ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag <= '0;
         ovf  <= '0;
      end else begin
         flag <= ev | (flag & ~ack);
         ovf  <= ovf_set | (ovf & ~ack);
      end
   end

   assign level = lvl;
   assign irq   = |flag;

endmodule
